// File: rtl/accel_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module  : accel_seq_pkg
// Brief   : Shared types for the accelerator sequencer: engine op codes and
//           sequencer state encoding, plus the enable-priority decoder.
// Rev     : 1.0
// ============================================================================
package accel_seq_pkg;

  typedef enum logic [1:0] {
    OP_IDLE = 2'b00,
    OP_ENCR = 2'b01,
    OP_DECR = 2'b10,
    OP_FFT  = 2'b11
  } accel_op_t;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RD   = 3'd1,
    S_RDW  = 3'd2,
    S_SEND = 3'd3,
    S_RECV = 3'd4,
    S_WR   = 3'd5,
    S_FIN  = 3'd6
  } seq_state_t;

  // Highest priority assignment wins: encr > decr > fft.
  function automatic accel_op_t op_select(input logic encr, input logic decr, input logic fft);
    accel_op_t op;
    op = OP_IDLE;
    if (fft)  op = OP_FFT;
    if (decr) op = OP_DECR;
    if (encr) op = OP_ENCR;
    return op;
  endfunction

endpackage
`default_nettype wire

// File: rtl/accel_seq_watchdog.sv
`default_nettype none
// ============================================================================
// Module  : accel_watchdog
// Brief   : Engine handshake watchdog; exists only when ACCEL_TIMEOUT_EN is
//           defined. Counts waiting cycles, expires on the TIMEOUT_CYCLES-th.
// Rev     : 1.0
// ============================================================================
`ifdef ACCEL_TIMEOUT_EN
module accel_watchdog #(
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en_i,
  input  logic clr_i,
  output logic expired_o
);

  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (!en_i || clr_i) cnt_d = '0;
    else                cnt_d = cnt_q + CW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  // A handshake in the final cycle still counts as progress.
  assign expired_o = en_i && !clr_i && (cnt_q == CW'(TIMEOUT_CYCLES - 1));

endmodule
`endif
`default_nettype wire

// File: rtl/accel_seq.sv
`default_nettype none
// ============================================================================
// Module  : accel_seq
// Brief   : Sequences encrypt/decrypt/FFT block ops: memory read -> engine ->
//           memory write per word, stalling the core until done.
//           Optional watchdog abort: ACCEL_TIMEOUT_EN.
// Rev     : 1.0
// ============================================================================
module accel_seq
  import accel_seq_pkg::*;
#(
  parameter int unsigned DW             = 32,
  parameter int unsigned AW             = 10,
  parameter int unsigned LW             = 8,
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          encr_en,
  input  logic          decr_en,
  input  logic          fft_en,
  input  logic [AW-1:0] src_addr,
  input  logic [AW-1:0] dst_addr,
  input  logic [LW-1:0] blk_len,
  output logic          stall,
  output logic          done,
  output logic          err,
  output logic [AW-1:0] mem_addr,
  output logic          mem_re,
  output logic          mem_we,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic [1:0]    eng_op,
  output logic          eng_in_valid,
  input  logic          eng_in_ready,
  output logic [DW-1:0] eng_in_data,
  input  logic          eng_out_valid,
  output logic          eng_out_ready,
  input  logic [DW-1:0] eng_out_data
);

  seq_state_t    state_q, state_d;
  accel_op_t     op_q, op_d;
  logic [AW-1:0] src_q, src_d, dst_q, dst_d;
  logic [LW-1:0] len_q, len_d, idx_q, idx_d;
  logic [DW-1:0] data_q, data_d;
  logic          any_en;
  logic          last_word;
  logic          wd_expired;

  assign any_en    = encr_en || decr_en || fft_en;
  assign last_word = (idx_q == (len_q - LW'(1)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      op_q    <= OP_IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      len_q   <= '0;
      idx_q   <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
    end
  end

  // data_q holds the source word through SEND and the engine result through WR.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    src_d   = src_q;
    dst_d   = dst_q;
    len_d   = len_q;
    idx_d   = idx_q;
    data_d  = data_q;
    case (state_q)
      S_IDLE: begin
        if (any_en) begin
          op_d    = op_select(encr_en, decr_en, fft_en);
          src_d   = src_addr;
          dst_d   = dst_addr;
          len_d   = blk_len;
          idx_d   = '0;
          state_d = (blk_len == '0) ? S_FIN : S_RD;
        end
      end
      S_RD:  state_d = S_RDW;
      S_RDW: begin
        data_d  = mem_rdata;
        state_d = S_SEND;
      end
      S_SEND: begin
        if (eng_in_ready)    state_d = S_RECV;
        else if (wd_expired) state_d = S_FIN;
      end
      S_RECV: begin
        if (eng_out_valid) begin
          data_d  = eng_out_data;
          state_d = S_WR;
        end else if (wd_expired) begin
          state_d = S_FIN;
        end
      end
      S_WR: begin
        idx_d   = idx_q + LW'(1);
        state_d = last_word ? S_FIN : S_RD;
      end
      S_FIN: begin
        op_d    = OP_IDLE;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // stall rises combinationally on the decode cycle; gated by rst_n so reset clears it at once.
  always_comb begin
    stall         = (state_q != S_IDLE) || (rst_n && any_en);
    done          = 1'b0;
    mem_re        = 1'b0;
    mem_we        = 1'b0;
    mem_addr      = '0;
    mem_wdata     = '0;
    eng_in_valid  = 1'b0;
    eng_in_data   = '0;
    eng_out_ready = 1'b0;
    case (state_q)
      S_RD: begin
        mem_re   = 1'b1;
        mem_addr = src_q + AW'(idx_q);
      end
      S_SEND: begin
        eng_in_valid = 1'b1;
        eng_in_data  = data_q;
      end
      S_RECV: eng_out_ready = 1'b1;
      S_WR: begin
        mem_we    = 1'b1;
        mem_addr  = dst_q + AW'(idx_q);
        mem_wdata = data_q;
      end
      S_FIN:   done = 1'b1;
      default: ;
    endcase
  end

  assign eng_op = op_q;

`ifdef ACCEL_TIMEOUT_EN
  logic wd_active;
  logic wd_kick;
  logic abort_q;

  assign wd_active = (state_q == S_SEND) || (state_q == S_RECV);
  assign wd_kick   = ((state_q == S_SEND) && eng_in_ready) ||
                     ((state_q == S_RECV) && eng_out_valid);

  accel_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk      (clk),
    .rst_n    (rst_n),
    .en_i     (wd_active),
    .clr_i    (wd_kick),
    .expired_o(wd_expired)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                abort_q <= 1'b0;
    else if (wd_expired)       abort_q <= 1'b1;
    else if (state_q == S_FIN) abort_q <= 1'b0;
  end

  assign err = (state_q == S_FIN) && abort_q;
`else
  assign wd_expired = 1'b0;
  assign err        = 1'b0;
`endif

endmodule
`default_nettype wire
